// File: rtl/decoder_scan_nto2n_if.sv
// Bus bundle for decoder_scan_nto2n: the select handshake, the scan controls
// and the registered one-hot outputs.
interface decoder_scan_nto2n_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 2 ** SEL_W;

  logic               en;
  logic               mode;
  logic               sel_valid;
  logic               sel_ready;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               busy;
  logic               wrap;

  modport master (
    output en, mode, sel_valid, sel, dwell,
    input  sel_ready, y, idx, busy, wrap
  );

  modport slave (
    input  en, mode, sel_valid, sel, dwell,
    output sel_ready, y, idx, busy, wrap
  );
endinterface

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with a direct (handshaked select) mode
// and a scan mode that walks the active bit with a programmable dwell.
module decoder_scan_nto2n #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder_scan_nto2n_if.slave   bus
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam logic [OUT_W-1:0] Y_OFF = ACT_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic               accept;
  logic [SEL_W-1:0]   idx_next;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] k);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return ACT_LOW ? ~v : v;
  endfunction

  // Ready falls with rst_n so nothing is accepted while the reset edge wins.
  assign bus.sel_ready = bus.en & ~bus.mode & rst_n;
  assign accept        = bus.sel_valid & bus.sel_ready;
  assign idx_next      = bus.idx + 1'b1;

  // NOTE: every register here uses <= so all state updates see pre-edge values;
  // the reset is synchronous, so it is simply the first branch of the edge block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus.y    <= Y_OFF;
      bus.idx  <= '0;
      bus.busy <= 1'b0;
      bus.wrap <= 1'b0;
      cnt      <= '0;
    end else if (!bus.en) begin
      state    <= IDLE;
      bus.y    <= Y_OFF;
      bus.idx  <= '0;
      bus.busy <= 1'b0;
      bus.wrap <= 1'b0;
    end else begin
      bus.wrap <= 1'b0;
      if (accept) begin
        // Also covers the SCAN exit edge: accept beats the fall to IDLE.
        state    <= DIRECT;
        bus.y    <= decode(bus.sel);
        bus.idx  <= bus.sel;
        bus.busy <= 1'b0;
      end else if (bus.mode && state != SCAN) begin
        state    <= SCAN;
        bus.y    <= decode('0);
        bus.idx  <= '0;
        bus.busy <= 1'b1;
        cnt      <= bus.dwell;
      end else if (!bus.mode && state == SCAN) begin
        state    <= IDLE;
        bus.y    <= Y_OFF;
        bus.idx  <= '0;
        bus.busy <= 1'b0;
      end else if (state == SCAN) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          // Dwell is sampled only here, so a mid-step change waits for reload.
          bus.idx  <= idx_next;
          bus.y    <= decode(idx_next);
          cnt      <= bus.dwell;
          bus.wrap <= (bus.idx == {SEL_W{1'b1}});
        end
      end
    end
  end
endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Scoreboard bench: stimulus queues expected outputs per edge, a negedge
// monitor pops and compares them against two decoder configurations.
module tb_decoder_scan_nto2n;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  decoder_scan_nto2n_if #(.SEL_W(3), .DWELL_W(8)) ifa ();
  decoder_scan_nto2n_if #(.SEL_W(4), .DWELL_W(8)) ifb ();

  decoder_scan_nto2n #(.SEL_W(3), .DWELL_W(8), .ACT_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(ifa));
  decoder_scan_nto2n #(.SEL_W(4), .DWELL_W(8), .ACT_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(ifb));

  typedef struct {
    int          due;
    bit          on_b;
    logic [15:0] y;
    logic [3:0]  idx;
    logic        busy;
    logic        wrap;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expectations apply to the state after the next rising edge.
  task automatic exp_a(input string n, input logic [7:0] y, input logic [2:0] i,
                       input logic b, input logic w);
    exp_t e;
    e = '{due: cyc + 1, on_b: 1'b0, y: {8'h00, y}, idx: {1'b0, i}, busy: b, wrap: w, name: n};
    sb.push_back(e);
  endtask

  task automatic exp_b(input string n, input logic [15:0] y, input logic [3:0] i,
                       input logic b, input logic w);
    exp_t e;
    e = '{due: cyc + 1, on_b: 1'b1, y: y, idx: i, busy: b, wrap: w, name: n};
    sb.push_back(e);
  endtask

  task automatic go_a(input logic r, input logic e, input logic m, input logic v,
                      input logic [2:0] s, input logic [7:0] d);
    @(negedge clk); #1;
    rst_a = r; ifa.en = e; ifa.mode = m; ifa.sel_valid = v; ifa.sel = s; ifa.dwell = d;
  endtask

  task automatic go_b(input logic r, input logic e, input logic m, input logic v,
                      input logic [3:0] s, input logic [7:0] d);
    @(negedge clk); #1;
    rst_b = r; ifb.en = e; ifb.mode = m; ifb.sel_valid = v; ifb.sel = s; ifb.dwell = d;
  endtask

  // Monitor: outputs are stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        if (!mon_e.on_b) begin
          check({mon_e.name, ".y"},    32'(ifa.y),    32'(mon_e.y));
          check({mon_e.name, ".idx"},  32'(ifa.idx),  32'(mon_e.idx));
          check({mon_e.name, ".busy"}, 32'(ifa.busy), 32'(mon_e.busy));
          check({mon_e.name, ".wrap"}, 32'(ifa.wrap), 32'(mon_e.wrap));
        end else begin
          check({mon_e.name, ".y"},    32'(ifb.y),    32'(mon_e.y));
          check({mon_e.name, ".idx"},  32'(ifb.idx),  32'(mon_e.idx));
          check({mon_e.name, ".busy"}, 32'(ifb.busy), 32'(mon_e.busy));
          check({mon_e.name, ".wrap"}, 32'(ifb.wrap), 32'(mon_e.wrap));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b0; ifa.en = 1'b1; ifa.mode = 1'b1; ifa.sel_valid = 1'b0; ifa.sel = '0; ifa.dwell = 8'd2;
    rst_b = 1'b0; ifb.en = 1'b0; ifb.mode = 1'b0; ifb.sel_valid = 1'b0; ifb.sel = '0; ifb.dwell = '0;

    // Reset held two edges with en=1, mode=1, then release enters SCAN.
    go_a(0, 1, 1, 0, 0, 2); exp_a("rst0", 8'h00, 0, 0, 0);
    #1 check("rst_ready", 32'(ifa.sel_ready), 32'd0);
    go_a(0, 1, 1, 0, 0, 2); exp_a("rst1", 8'h00, 0, 0, 0);
    go_a(1, 1, 1, 0, 0, 2); exp_a("rst_release_scan", 8'h01, 0, 1, 0);
    go_a(1, 0, 0, 0, 0, 2); exp_a("en_off", 8'h00, 0, 0, 0);

    // Direct sweep, one accept every 10 cycles.
    for (int k = 0; k < 8; k++) begin
      go_a(1, 1, 0, 1, 3'(k), 0); exp_a("dir", 8'(1 << k), 3'(k), 0, 0);
      #1 check("dir_ready", 32'(ifa.sel_ready), 32'd1);
      for (int i = 1; i < 10; i++) begin
        go_a(1, 1, 0, 0, 3'(k), 0);
        if (i == 9) exp_a("dir_hold", 8'(1 << k), 3'(k), 0, 0);
      end
    end

    // Handshake: sel=2 offered while mode=1 must be refused.
    go_a(1, 1, 0, 1, 5, 3); exp_a("hs_sel5", 8'h20, 5, 0, 0);
    go_a(1, 1, 0, 0, 2, 3); exp_a("hs_gap", 8'h20, 5, 0, 0);
    go_a(1, 1, 1, 1, 2, 3); exp_a("hs_sel2_refused", 8'h01, 0, 1, 0);
    #1 check("hs_ready_low", 32'(ifa.sel_ready), 32'd0);
    go_a(1, 1, 1, 0, 2, 3); exp_a("hs_scan_hold", 8'h01, 0, 1, 0);
    go_a(1, 1, 0, 1, 6, 3); exp_a("hs_sel6_on_exit", 8'h40, 6, 0, 0);
    #1 check("hs_ready_exit", 32'(ifa.sel_ready), 32'd1);
    go_a(1, 1, 1, 0, 0, 3); exp_a("hs_rescan", 8'h01, 0, 1, 0);
    go_a(1, 1, 0, 0, 0, 3); exp_a("hs_exit_off", 8'h00, 0, 0, 0);

    // Scan dwell=2, wrap 24 edges after entry, then dwell=0 mid-step.
    go_a(1, 1, 1, 0, 0, 2); exp_a("scan_entry", 8'h01, 0, 1, 0);
    for (int j = 1; j <= 24; j++) begin
      go_a(1, 1, 1, 0, 0, 2);
      exp_a("scan_d2", 8'(1 << ((j / 3) % 8)), 3'((j / 3) % 8), 1, j == 24);
    end
    for (int j = 25; j <= 34; j++) begin
      go_a(1, 1, 1, 0, 0, 0);
      exp_a("scan_d0", 8'(1 << ((j < 27) ? 0 : (j - 26) % 8)),
            3'((j < 27) ? 0 : (j - 26) % 8), 1, j == 34);
    end

    // Abort via en at idx=5 mid-dwell, then restart with full dwell.
    go_a(1, 0, 0, 0, 0, 3); exp_a("abort_clear", 8'h00, 0, 0, 0);
    go_a(1, 1, 1, 0, 0, 3); exp_a("abort_entry", 8'h01, 0, 1, 0);
    for (int j = 1; j <= 21; j++) begin
      go_a(1, 1, 1, 0, 0, 3); exp_a("abort_walk", 8'(1 << (j / 4)), 3'(j / 4), 1, 0);
    end
    go_a(1, 0, 1, 1, 3, 3); exp_a("abort_en", 8'h00, 0, 0, 0);
    go_a(1, 1, 1, 0, 0, 3); exp_a("abort_reentry", 8'h01, 0, 1, 0);
    for (int j = 1; j <= 4; j++) begin
      go_a(1, 1, 1, 0, 0, 3); exp_a("abort_full_dwell", 8'(1 << (j / 4)), 3'(j / 4), 1, 0);
    end

    // Same abort with rst_n.
    go_a(1, 0, 0, 0, 0, 3); exp_a("rabort_clear", 8'h00, 0, 0, 0);
    go_a(1, 1, 1, 0, 0, 3); exp_a("rabort_entry", 8'h01, 0, 1, 0);
    for (int j = 1; j <= 21; j++) begin
      go_a(1, 1, 1, 0, 0, 3); exp_a("rabort_walk", 8'(1 << (j / 4)), 3'(j / 4), 1, 0);
    end
    go_a(0, 1, 1, 0, 0, 3); exp_a("rabort_rst", 8'h00, 0, 0, 0);
    go_a(1, 1, 1, 0, 0, 3); exp_a("rabort_reentry", 8'h01, 0, 1, 0);
    for (int j = 1; j <= 4; j++) begin
      go_a(1, 1, 1, 0, 0, 3); exp_a("rabort_full_dwell", 8'(1 << (j / 4)), 3'(j / 4), 1, 0);
    end
    go_a(1, 0, 0, 0, 0, 0); exp_a("a_park", 8'h00, 0, 0, 0);

    // SEL_W=4, ACT_LOW=1 instance.
    go_b(0, 0, 0, 0, 0, 0); exp_b("b_rst", 16'hFFFF, 0, 0, 0);
    go_b(1, 1, 0, 1, 9, 0); exp_b("b_dir9", 16'hFDFF, 9, 0, 0);
    go_b(1, 1, 1, 0, 0, 0); exp_b("b_scan_entry", 16'hFFFE, 0, 1, 0);
    for (int j = 1; j <= 32; j++) begin
      go_b(1, 1, 1, 0, 0, 0);
      exp_b("b_scan_d0", ~16'(1 << (j % 16)), 4'(j % 16), 1, (j % 16) == 0);
    end

    repeat (2) @(negedge clk);
    #2 check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
